// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side adapter for an asynchronous FIFO, running in the FIFO read clock
//   domain. Pops FIFO words whenever buffer space exists and presents them on a
//   valid/ready stream through a 2-entry registered buffer. The pop has no
//   combinational dependency on m_ready, so the FIFO timing is isolated from
//   the consumer while still sustaining one word per cycle.
//
// Ports
//   clk         read-domain clock (same as FIFO rclk)
//   rstn        asynchronous active-low reset
//   fifo_empty  FIFO registered empty flag
//   fifo_dout   FIFO read data, valid while fifo_empty = 0
//   fifo_rden   FIFO pop; word on fifo_dout consumed at this edge
//   m_valid     output stream valid
//   m_ready     output stream ready
//   m_data      output stream data (buffer head)
//   flush       synchronous flush of buffered words
//   xfer_cnt    wrapping count of completed output handshakes
module fifo_rd_stream #(
    parameter int DWIDTH = 8,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_rden,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    input  logic              flush,
    output logic [CNTW-1:0]   xfer_cnt
);

    logic [1:0]        cnt;
    logic [1:0]        cnt_next;
    logic [DWIDTH-1:0] e0;
    logic [DWIDTH-1:0] e1;
    logic              armed;
    logic              pop;
    logic              fire;

    // The FIFO empty flag is only trustworthy one cycle after reset, so pops
    // stay masked until armed is set.
    assign pop       = armed & ~fifo_empty & (cnt != 2'd2) & ~flush;
    assign fifo_rden = pop;
    assign m_valid   = (cnt != 2'd0) & ~flush;
    assign fire      = m_valid & m_ready;
    assign m_data    = e0;

    always_comb begin
        cnt_next = cnt;
        if (flush) begin
            cnt_next = '0;
        end else if (pop && !fire) begin
            cnt_next = cnt + 2'd1;
        end else if (!pop && fire) begin
            cnt_next = cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            e0       <= '0;
            e1       <= '0;
            armed    <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            armed <= 1'b1;
            cnt   <= cnt_next;

            // pop and fire are both forced low during flush, so no data moves
            unique case (cnt)
                2'd0: begin
                    if (pop) e0 <= fifo_dout;
                end
                2'd1: begin
                    // with fire and no pop e0 goes stale; cnt drops to 0
                    if (pop && fire)  e0 <= fifo_dout;
                    if (pop && !fire) e1 <= fifo_dout;
                end
                2'd2: begin
                    if (fire) e0 <= e1;
                end
                default: ;
            endcase

            if (fire) xfer_cnt <= xfer_cnt + CNTW'(1);
        end
    end

endmodule
